scc_sram_initiator: RTL
=======================

SCC_SRAM_INITIATOR -- requirements
Module: scc_sram_initiator

Interface
REQ-001 Parameter DECODE_SCCI_ONLY, default 0, meaning: 1 forces SCC-I address decode regardless of reg_scci_enable.
REQ-002 nreset  input  1  asynchronous active-low reset.
REQ-003 clk  input  1  single clock; every flop is clocked on its rising edge.
REQ-004 bus_address  input  8  byte offset within the SCC register window.
REQ-005 bus_wdata  input  8  write data.
REQ-006 bus_rd_req / bus_wr_req  input  1 each  single-cycle request strobes, already synchronous to clk.
REQ-007 reg_scci_enable  input  1  0 = SCC decode, 1 = SCC-I decode.
REQ-008 err_clear  input  1  clears the sticky error flags.
REQ-009 bus_rdata  output  8  read data; bus_rdata_en  output  1  one-cycle valid strobe.
REQ-010 bus_busy  output  1  high while a request is in flight or queued.
REQ-011 err_overflow / err_timeout  output  1 each  sticky error flags.
REQ-012 sram_id  output  3  channel select (A..E = 0..4); sram_a  output  5  wave address; sram_d  output  8  write data.
REQ-013 sram_oe / sram_we  output  1 each  single-cycle access strobes; never both high in the same cycle.
REQ-014 sram_q  input  8  read data from the wave RAM; sram_q_en  input  1  read-data-valid strobe.

Function
REQ-015 Decode when reg_scci_enable=0 and DECODE_SCCI_ONLY=0: offsets 0x00-0x7F map to SRAM with id={0,addr[6:5]} and a=addr[4:0]; all other offsets are non-SRAM.
REQ-016 Decode in SCC-I mode: offsets 0x00-0x9F map to SRAM with id=addr[7:5] and a=addr[4:0]; offsets 0xA0-0xFF are non-SRAM.
REQ-017 The FSM has states IDLE, ISSUE, WAIT and RESP, and resets to IDLE.
REQ-018 A request accepted in IDLE at cycle R moves the FSM to ISSUE at R+1; all sram_* outputs are registered and valid during ISSUE.
REQ-019 An SRAM write asserts sram_we for exactly one cycle in ISSUE and then returns to IDLE, or goes straight to ISSUE if a request is queued.
REQ-020 An SRAM read asserts sram_oe for exactly one cycle in ISSUE and then enters WAIT.
REQ-021 In WAIT, sram_q is latched on the first cycle with sram_q_en=1; the FSM then enters RESP, and bus_rdata_en=1 during RESP (nominal latency: request R, data strobe R+3).
REQ-022 If sram_q_en stays low for 4 consecutive WAIT cycles, the block returns 0xFF in RESP and sets err_timeout.
REQ-023 A non-SRAM read takes the same path with sram_oe suppressed and returns 0xFF at R+3.
REQ-024 A non-SRAM write generates no strobe, is not queued, and does not raise bus_busy.
REQ-025 A one-entry queue holds a request arriving while the FSM is not in IDLE; the queued request is issued on the cycle after the current transaction completes.
REQ-026 A request arriving while the queue is full is dropped and sets err_overflow.
REQ-027 If bus_rd_req and bus_wr_req are high in the same cycle, the write is accepted, the read is dropped, and err_overflow is set.
REQ-028 bus_busy = (state != IDLE) OR queue_valid.
REQ-029 When err_clear coincides with a new error event, the error wins and the flag stays set.
REQ-030 sram_id, sram_a and sram_d hold their last values when no strobe is active.

Reset
REQ-031 While nreset=0: FSM=IDLE, queue empty, timeout counter=0, and every output is 0 (bus_rdata=8'h00).
REQ-032 Reset asserted mid-transaction aborts it immediately: no strobe and no bus_rdata_en is issued after reset releases.

Structure
REQ-033 The shared package scc_pkg holds the FSM state encodings, the timeout limit (4), the non-SRAM read value (8'hFF) and the SCC/SCC-I decode limits (0x7F, 0x9F).
REQ-034 One sub-module, scc_address_decoder, is combinational: inputs are address, mode and DECODE_SCCI_ONLY; outputs are is_sram, id and a.

Verification
REQ-035 Scenario: SCC-I write addr 0x85, data 0x5A at R -> R+1 sram_we=1, sram_id=4, sram_a=5, sram_d=0x5A; bus_busy low at R+2.
REQ-036 Scenario: SCC read addr 0x63, with the responder returning q_en at R+2 and q=0x3C -> R+1 sram_oe=1, sram_id=3, sram_a=3; R+3 bus_rdata_en=1, bus_rdata=0x3C.
REQ-037 Scenario: read, with a write to 0x10 one cycle later and a third request one cycle after that -> the write is issued after the read completes, the third request is dropped, and err_overflow=1.
REQ-038 Scenario: read with the responder never asserting q_en -> bus_rdata=0xFF after 4 WAIT cycles; err_timeout=1; err_clear then returns it to 0.
REQ-039 Scenario: SCC-mode read addr 0x90 -> no sram_oe, bus_rdata=0xFF at R+3; SCC-mode write addr 0x90 -> no strobe, bus_busy stays 0.
REQ-040 Scenario: nreset pulsed during WAIT -> all outputs 0, FSM back to IDLE, no late bus_rdata_en.

Source files
------------

// File: rtl/scc_pkg.sv
// Shared definitions for the SCC wave-RAM initiator: FSM encodings,
// timing limits, decode limits and the request record.
package scc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Number of consecutive WAIT cycles without sram_q_en before giving up
  localparam int unsigned TIMEOUT_LIMIT = 4;
  localparam logic [2:0]  TIMEOUT_LAST  = 3'(TIMEOUT_LIMIT - 1);

  // Value returned for reads that do not reach the wave RAM
  localparam logic [7:0]  NON_SRAM_RDATA = 8'hFF;

  // Highest wave-RAM offset in each memory map
  localparam logic [7:0]  SCC_SRAM_LIMIT  = 8'h7F;
  localparam logic [7:0]  SCCI_SRAM_LIMIT = 8'h9F;

  // One decoded bus request, as held in the queue or issued to the RAM
  typedef struct packed {
    logic       write;
    logic       is_sram;
    logic [2:0] id;
    logic [4:0] a;
    logic [7:0] d;
  } req_t;

endpackage

// File: rtl/scc_address_decoder.sv
// Combinational SCC / SCC-I register-window decoder: splits a byte offset
// into a wave-RAM channel and address, and flags offsets outside the RAM.
module scc_address_decoder
  import scc_pkg::*;
(
  input  logic [7:0] address,
  input  logic       mode,
  input  logic       scci_only,
  output logic       is_sram,
  output logic [2:0] id,
  output logic [4:0] a
);

  // SCC-I maps five channels over 0x00-0x9F, plain SCC only four over 0x00-0x7F
  always_comb begin
    a = address[4:0];
    if (mode || scci_only) begin
      is_sram = (address <= SCCI_SRAM_LIMIT);
      id      = address[7:5];
    end else begin
      is_sram = (address <= SCC_SRAM_LIMIT);
      id      = {1'b0, address[6:5]};
    end
  end

endmodule

// File: rtl/scc_sram_initiator.sv
// Bus-to-wave-RAM initiator for the SCC sound chip: decodes register
// accesses, issues single-cycle RAM strobes, waits for read data with a
// timeout, and buffers one request that arrives while busy.
module scc_sram_initiator
  import scc_pkg::*;
#(
  parameter bit DECODE_SCCI_ONLY = 1'b0
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic [7:0] bus_address,
  input  logic [7:0] bus_wdata,
  input  logic       bus_rd_req,
  input  logic       bus_wr_req,
  input  logic       reg_scci_enable,
  input  logic       err_clear,
  output logic [7:0] bus_rdata,
  output logic       bus_rdata_en,
  output logic       bus_busy,
  output logic       err_overflow,
  output logic       err_timeout,
  output logic [2:0] sram_id,
  output logic [4:0] sram_a,
  output logic [7:0] sram_d,
  output logic       sram_oe,
  output logic       sram_we,
  input  logic [7:0] sram_q,
  input  logic       sram_q_en
);

  state_t     state, state_next;
  logic [2:0] cnt, cnt_next;
  logic       q_valid;
  req_t       q_req;
  logic       cur_write, cur_is_sram;

  logic       dec_is_sram;
  logic [2:0] dec_id;
  logic [4:0] dec_a;

  req_t       in_req, issue_req;
  logic       in_valid, in_taken;
  logic       issue, q_pop, q_push;
  logic       resp_load, timeout_evt, overflow_evt;
  logic [7:0] resp_data;

  scc_address_decoder u_decoder (
    .address   (bus_address),
    .mode      (reg_scci_enable),
    .scci_only (DECODE_SCCI_ONLY),
    .is_sram   (dec_is_sram),
    .id        (dec_id),
    .a         (dec_a)
  );

  assign bus_busy = (state != ST_IDLE) || q_valid;

  // Form the incoming request; a write wins over a simultaneous read, and a
  // write outside the RAM is simply ignored
  always_comb begin
    in_req   = '{write: bus_wr_req, is_sram: dec_is_sram, id: dec_id, a: dec_a, d: bus_wdata};
    in_valid = bus_wr_req ? dec_is_sram : bus_rd_req;
  end

  // Next-state logic: choose what to issue, when to respond and how the queue moves
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    issue       = 1'b0;
    issue_req   = q_req;
    q_pop       = 1'b0;
    in_taken    = 1'b0;
    resp_load   = 1'b0;
    resp_data   = NON_SRAM_RDATA;
    timeout_evt = 1'b0;
    case (state)
      ST_IDLE: begin
        if (q_valid) begin
          issue = 1'b1;
          q_pop = 1'b1;
        end else if (in_valid) begin
          issue     = 1'b1;
          issue_req = in_req;
          in_taken  = 1'b1;
        end
      end
      ST_ISSUE: begin
        if (!cur_write) begin
          state_next = ST_WAIT;
          cnt_next   = '0;
        end else if (q_valid) begin
          issue = 1'b1;
          q_pop = 1'b1;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!cur_is_sram) begin
          resp_load = 1'b1;
        end else if (sram_q_en) begin
          resp_load = 1'b1;
          resp_data = sram_q;
        end else if (cnt == TIMEOUT_LAST) begin
          resp_load   = 1'b1;
          timeout_evt = 1'b1;
        end else begin
          cnt_next = cnt + 3'd1;
        end
        if (resp_load) begin
          state_next = ST_RESP;
          cnt_next   = '0;
        end
      end
      ST_RESP: begin
        if (q_valid) begin
          issue = 1'b1;
          q_pop = 1'b1;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    if (issue) begin
      state_next = ST_ISSUE;
    end
    // The slot is free if empty or being drained this cycle
    q_push       = in_valid && !in_taken && (!q_valid || q_pop);
    overflow_evt = (bus_rd_req && bus_wr_req) || (in_valid && !in_taken && q_valid && !q_pop);
  end

  // State register, timeout counter, queue slot and current-transaction type
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      q_valid     <= 1'b0;
      q_req       <= '0;
      cur_write   <= 1'b0;
      cur_is_sram <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (issue) begin
        cur_write   <= issue_req.write;
        cur_is_sram <= issue_req.is_sram;
      end
      if (q_push) begin
        q_valid <= 1'b1;
        q_req   <= in_req;
      end else if (q_pop) begin
        q_valid <= 1'b0;
      end
    end
  end

  // Registered RAM strobes, read response and sticky error flags
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      sram_we      <= 1'b0;
      sram_oe      <= 1'b0;
      sram_id      <= '0;
      sram_a       <= '0;
      sram_d       <= '0;
      bus_rdata    <= '0;
      bus_rdata_en <= 1'b0;
      err_overflow <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      sram_we      <= issue && issue_req.is_sram && issue_req.write;
      sram_oe      <= issue && issue_req.is_sram && !issue_req.write;
      bus_rdata_en <= resp_load;
      if (issue && issue_req.is_sram) begin
        sram_id <= issue_req.id;
        sram_a  <= issue_req.a;
        sram_d  <= issue_req.d;
      end
      if (resp_load) begin
        bus_rdata <= resp_data;
      end
      if (overflow_evt) begin
        err_overflow <= 1'b1;
      end else if (err_clear) begin
        err_overflow <= 1'b0;
      end
      if (timeout_evt) begin
        err_timeout <= 1'b1;
      end else if (err_clear) begin
        err_timeout <= 1'b0;
      end
    end
  end

endmodule
